z80_bus_mem_responder: RTL and testbench
========================================

// Module: z80_bus_mem_responder
// PURPOSE
// - Bus-slave end of the tv80s memory/IO interface. It decodes mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n,
//   serves reads from internal RAM/IO arrays on di, and commits writes from dout.
// - Inserts programmable wait states through wait_n.
// - Exposes a backdoor port for preload/inspection and write/fetch trace registers for self-checking benches.
// - Sits between tv80s and the bench: replaces the behavioural negedge memory model in the CPU test harnesses.
// PARAMETERS
// - MEM_AW    16  RAM address width; RAM depth is 2**MEM_AW, addressed by A[MEM_AW-1:0]
// - MEM_WAIT   0  wait cycles inserted on every memory read/write (0..15)
// - IO_WAIT    1  wait cycles inserted on every IO read/write (0..15)
// - INTA_DATA  8'hFF  byte returned on interrupt-acknowledge (iorq_n=0 & m1_n=0)
// PORTS
// - clk            in   1   CPU clock; all state updates on posedge
// - reset          in   1   asynchronous, active-high
// - mreq_n         in   1   memory request from CPU
// - iorq_n         in   1   IO request from CPU
// - rd_n           in   1   read strobe
// - wr_n           in   1   write strobe
// - m1_n           in   1   opcode-fetch / int-ack qualifier
// - rfsh_n         in   1   refresh qualifier; refresh cycles are ignored
// - A              in   16  address bus
// - dout           in   8   CPU write data
// - di             out  8   read data to CPU
// - wait_n         out  1   low = stretch current access
// - bd_we          in   1   backdoor RAM write strobe
// - bd_addr        in   16  backdoor address
// - bd_wdata       in   8   backdoor write data
// - bd_rdata       out  8   backdoor read data (registered, 1-cycle latency)
// - last_wr_addr   out  16  address of most recent committed bus write (memory or IO)
// - last_wr_data   out  8   data of most recent committed bus write
// - last_wr_io     out  1   1 = most recent committed write was IO
// - wr_count       out  16  committed bus writes since reset (saturates at FFFF)
// - m1_count       out  16  completed opcode fetches since reset (saturates at FFFF)
// BEHAVIOUR
// - Reset values: di=8'hFF, wait_n=1, bd_rdata=0, last_wr_*=0, wr_count=0, m1_count=0, FSM=IDLE.
//   Array contents are NOT cleared. Reset mid-access aborts it: no write is committed.
// - Access qualifiers:
//   - mem_acc = !mreq_n & rfsh_n & (!rd_n | !wr_n)
//   - io_acc  = !iorq_n & m1_n & (!rd_n | !wr_n)
//   - inta    = !iorq_n & !m1_n
// - FSM states IDLE, WAIT, ACTIVE, DONE:
//   - IDLE -> WAIT on a new access with a nonzero wait count; cnt loads (MEM_WAIT or IO_WAIT)-1 and wait_n=0.
//   - IDLE -> ACTIVE on a new access with a zero wait count.
//   - WAIT decrements cnt while holding wait_n=0; at cnt==0 -> ACTIVE, and wait_n returns to 1 in the same cycle.
//   - ACTIVE: commits a write, if any, exactly once, using A and dout sampled in this cycle; -> DONE.
//   - DONE is held until all strobes deassert (rd_n & wr_n & mreq_n & iorq_n), then -> IDLE.
//   - A strobe released in WAIT -> IDLE, with wait_n=1 and no commit.
// - Reads:
//   - di <= RAM[A] (memory), IO[A[7:0]] (IO) or INTA_DATA (inta), registered every posedge while the access is
//     qualified, so data is valid one cycle after the qualifier and stable through waits.
//   - di holds its last value between accesses.
// - m1_count increments once per fetch: on the IDLE exit of an access with !m1_n & !mreq_n & !rd_n.
// - wr_count increments, and last_wr_* update, on each ACTIVE write commit.
// - Backdoor:
//   - bd_we writes RAM[bd_addr] on posedge.
//   - If it collides with a bus write commit in the same cycle to the same address, the bus write wins.
//   - bd_rdata <= RAM[bd_addr] every cycle. A backdoor write is visible to the next bus read.
// - Counter wrap: wr_count/m1_count saturate, never wrap. Address bits above MEM_AW are ignored (aliasing).
// STRUCTURE
// - Package z80_bus_pkg:
//   - typedef resp_state_t {IDLE, WAIT, ACTIVE, DONE}
//   - localparam DI_IDLE = 8'hFF
//   - access-kind enum {ACC_NONE, ACC_MEM, ACC_IO, ACC_INTA}
// - One sub-module, z80_wait_gen: access start + wait count -> wait_n and expiry pulse.
// - RAM and IO arrays are inferred in this module.
// TESTING
// 1. DDCB run with tv80s, MEM_WAIT=0:
//    - Stimulus: preload DD CB 62 8B @0000 and 8A @16E7; IX=1685; run 23 clocks.
//    - Expect: RAM[16E7]=88, last_wr_addr=16E7, last_wr_data=88, wr_count=1, PC=0004.
// 2. Same as 1 with MEM_WAIT=2:
//    - Expect: identical final state; wait_n low exactly 2 cycles per access; total cycles grow accordingly.
// 3. Direct bus IO write of 5A to port 0x34, then IO read of port 0x34 (IO_WAIT=1):
//    - Expect: di=5A; wait_n low 1 cycle on each access; last_wr_io=1.
// 4. Interrupt acknowledge (iorq_n=0, m1_n=0):
//    - Expect: di=FF; no write commit; m1_count unchanged.
// 5. Collision: bd_we to 1000=11 in the same cycle the bus commits 22 to 1000.
//    - Expect: RAM[1000]=22.
// 6. Reset asserted mid-WAIT of a write to 2000 (MEM_WAIT=3):
//    - Expect: wait_n=1 immediately, RAM[2000] unchanged, wr_count=0, di=FF.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the tv80s bus-slave memory responder.
package z80_bus_pkg;

  // Responder FSM encoding. Plain constants keep it usable from older tools.
  typedef logic [1:0] resp_state_t;
  localparam resp_state_t IDLE   = 2'd0;
  localparam resp_state_t WAIT   = 2'd1;
  localparam resp_state_t ACTIVE = 2'd2;
  localparam resp_state_t DONE   = 2'd3;

  // Value on di before any read has completed.
  localparam logic [7:0] DI_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_MEM,
    ACC_IO,
    ACC_INTA
  } acc_kind_t;

  // Wait-state count that applies to a given access kind.
  function automatic logic [3:0] wait_cycles(acc_kind_t kind, logic [3:0] mem_w,
                                             logic [3:0] io_w);
    logic [3:0] n;
    n = 4'd0;
    if (kind == ACC_MEM) n = mem_w;
    else if (kind == ACC_IO) n = io_w;
    return n;
  endfunction

endpackage

// File: rtl/z80_bus_mem_responder_if.sv
// tv80s memory/IO bus as seen between the CPU (master) and a responder (slave).
interface z80_bus_mem_responder_if;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        wait_n;

  modport master (
    output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, A, dout,
    input  di, wait_n
  );

  modport slave (
    input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, A, dout,
    output di, wait_n
  );
endinterface

// File: rtl/z80_wait_gen.sv
// Wait-state generator: holds wait_n low for the requested number of cycles
// after an access starts and flags the last waited cycle with expire.
module z80_wait_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cycles,
  input  logic       abort,
  output logic       wait_n,
  output logic       expire
);

  logic       busy_q;
  logic [3:0] cnt_q;

  // Count down the remaining wait cycles; abort drops the stretch at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else if (busy_q) begin
      if (abort || cnt_q == 4'd0) busy_q <= 1'b0;
      else cnt_q <= cnt_q - 4'd1;
    end else if (start && cycles != 4'd0) begin
      busy_q <= 1'b1;
      cnt_q  <= cycles - 4'd1;
    end
  end

  // wait_n follows the busy flag so it rises in the cycle the access goes active.
  always_comb begin
    wait_n = ~busy_q;
    expire = busy_q & (cnt_q == 4'd0) & ~abort;
  end

endmodule

// File: rtl/z80_bus_mem_responder.sv
// Bus-slave memory/IO responder for tv80s: serves reads from internal RAM/IO
// arrays, commits writes once per access, inserts wait states, and exposes a
// backdoor port plus write/fetch trace registers.
module z80_bus_mem_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned MEM_AW    = 16,
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned IO_WAIT   = 1,
  parameter logic [7:0]  INTA_DATA = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  z80_bus_mem_responder_if.slave   bus,
  input  logic                     bd_we,
  input  logic [15:0]              bd_addr,
  input  logic [7:0]               bd_wdata,
  output logic [7:0]               bd_rdata,
  output logic [15:0]              last_wr_addr,
  output logic [7:0]               last_wr_data,
  output logic                     last_wr_io,
  output logic [15:0]              wr_count,
  output logic [15:0]              m1_count
);

  localparam int unsigned MemDepth = 2 ** MEM_AW;

  logic [7:0] ram    [MemDepth];
  logic [7:0] io_mem [256];

  resp_state_t state_q, state_d;
  acc_kind_t   kind_q, kind_d;

  logic        mem_acc, io_acc, inta, acc, fetch, commit, all_idle;
  logic        start, abort, expire, wait_n_w;
  logic [3:0]  wcnt;

  logic [7:0]  di_q, bd_rdata_q, last_wr_data_q;
  logic [15:0] last_wr_addr_q, wr_count_q, m1_count_q;
  logic        last_wr_io_q;

  // Decode the bus strobes into access kind and qualifiers.
  always_comb begin
    mem_acc  = ~bus.mreq_n & bus.rfsh_n & (~bus.rd_n | ~bus.wr_n);
    io_acc   = ~bus.iorq_n & bus.m1_n & (~bus.rd_n | ~bus.wr_n);
    inta     = ~bus.iorq_n & ~bus.m1_n;
    acc      = mem_acc | io_acc;
    fetch    = ~bus.m1_n & ~bus.mreq_n & ~bus.rd_n;
    all_idle = bus.rd_n & bus.wr_n & bus.mreq_n & bus.iorq_n;
    kind_d   = mem_acc ? ACC_MEM : io_acc ? ACC_IO : inta ? ACC_INTA : ACC_NONE;
    wcnt     = wait_cycles(kind_d, 4'(MEM_WAIT), 4'(IO_WAIT));
  end

  // Access sequencing: optional wait, single commit cycle, then wait for release.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (wcnt != 4'd0) begin
            state_d = WAIT;
            start   = 1'b1;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      WAIT: begin
        if (!acc) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (expire) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE:  state_d = DONE;
      DONE:    if (all_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit only while the write strobe is still qualified in the ACTIVE cycle.
  always_comb commit = (state_q == ACTIVE) & ~bus.wr_n & acc;

  // FSM state and latched access kind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= ACC_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && acc) kind_q <= kind_d;
    end
  end

  z80_wait_gen u_wait_gen (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cycles (wcnt),
    .abort  (abort),
    .wait_n (wait_n_w),
    .expire (expire)
  );

  // Array writes; the bus commit is last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bd_we) ram[bd_addr[MEM_AW-1:0]] <= bd_wdata;
    if (commit && kind_q == ACC_MEM) ram[bus.A[MEM_AW-1:0]] <= bus.dout;
    if (commit && kind_q == ACC_IO) io_mem[bus.A[7:0]] <= bus.dout;
  end

  // Read data and backdoor read-out; di holds between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      di_q       <= DI_IDLE;
      bd_rdata_q <= 8'h00;
    end else begin
      bd_rdata_q <= ram[bd_addr[MEM_AW-1:0]];
      if (mem_acc) di_q <= ram[bus.A[MEM_AW-1:0]];
      else if (io_acc) di_q <= io_mem[bus.A[7:0]];
      else if (inta) di_q <= INTA_DATA;
    end
  end

  // Write trace and saturating write/fetch counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr_addr_q <= 16'h0000;
      last_wr_data_q <= 8'h00;
      last_wr_io_q   <= 1'b0;
      wr_count_q     <= 16'h0000;
      m1_count_q     <= 16'h0000;
    end else begin
      if (commit) begin
        last_wr_addr_q <= bus.A;
        last_wr_data_q <= bus.dout;
        last_wr_io_q   <= (kind_q == ACC_IO);
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end
      if (state_q == IDLE && acc && fetch && m1_count_q != 16'hFFFF) begin
        m1_count_q <= m1_count_q + 16'd1;
      end
    end
  end

  // Drive outputs from registered state.
  always_comb begin
    bus.di       = di_q;
    bus.wait_n   = wait_n_w;
    bd_rdata     = bd_rdata_q;
    last_wr_addr = last_wr_addr_q;
    last_wr_data = last_wr_data_q;
    last_wr_io   = last_wr_io_q;
    wr_count     = wr_count_q;
    m1_count     = m1_count_q;
  end

endmodule

// File: tb/tb_z80_bus_mem_responder.sv
// Directed bench: one responder with wait states (MEM_WAIT=2, IO_WAIT=1) and a
// zero-wait twin on the same bus; read data checked through a scoreboard queue.
module tb_z80_bus_mem_responder;
  import z80_bus_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] d0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'h0000;
  logic [7:0]  bd_wdata = 8'h00;

  logic [7:0]  bd_rdata, bd_rdata0, last_wr_data, last_wr_data0;
  logic [15:0] last_wr_addr, last_wr_addr0, wr_count, wr_count0, m1_count, m1_count0;
  logic        last_wr_io, last_wr_io0;

  int pass_cnt = 0;
  int fail_cnt = 0;

  exp_t       exp_q[$];
  logic [7:0] mem_m [int];
  logic [7:0] mem0_m[int];
  logic [15:0] e_addr = 16'h0000;
  logic [7:0]  e_data = 8'h00;
  logic        e_io = 1'b0;
  logic [15:0] e_wr = 16'h0000;
  logic [15:0] e_m1 = 16'h0000;

  z80_bus_mem_responder_if bus ();
  z80_bus_mem_responder_if bus0 ();

  assign bus0.mreq_n = bus.mreq_n;
  assign bus0.iorq_n = bus.iorq_n;
  assign bus0.rd_n   = bus.rd_n;
  assign bus0.wr_n   = bus.wr_n;
  assign bus0.m1_n   = bus.m1_n;
  assign bus0.rfsh_n = bus.rfsh_n;
  assign bus0.A      = bus.A;
  assign bus0.dout   = bus.dout;

  z80_bus_mem_responder #(.MEM_AW(16), .MEM_WAIT(2), .IO_WAIT(1), .INTA_DATA(8'hFF)) dut (
    .clk (clk), .reset (reset), .bus (bus.slave),
    .bd_we (bd_we), .bd_addr (bd_addr), .bd_wdata (bd_wdata), .bd_rdata (bd_rdata),
    .last_wr_addr (last_wr_addr), .last_wr_data (last_wr_data), .last_wr_io (last_wr_io),
    .wr_count (wr_count), .m1_count (m1_count)
  );

  z80_bus_mem_responder #(.MEM_AW(16), .MEM_WAIT(0), .IO_WAIT(0), .INTA_DATA(8'hFF)) dut0 (
    .clk (clk), .reset (reset), .bus (bus0.slave),
    .bd_we (bd_we), .bd_addr (bd_addr), .bd_wdata (bd_wdata), .bd_rdata (bd_rdata0),
    .last_wr_addr (last_wr_addr0), .last_wr_data (last_wr_data0), .last_wr_io (last_wr_io0),
    .wr_count (wr_count0), .m1_count (m1_count0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.mreq_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.m1_n = 1'b1; bus.rfsh_n = 1'b1;
  endtask

  task automatic bd_write(input logic [15:0] addr, input logic [7:0] data);
    bd_addr = addr; bd_wdata = data; bd_we = 1'b1;
    @(posedge clk); @(negedge clk);
    bd_we = 1'b0;
    mem_m[int'(addr)] = data;
    mem0_m[int'(addr)] = data;
  endtask

  task automatic bd_check(input string tag, input logic [15:0] addr, input logic [7:0] e,
                          input logic [7:0] e0);
    bd_addr = addr;
    @(posedge clk); @(negedge clk);
    chk({tag, " bd_rdata"}, 32'(bd_rdata), 32'(e));
    chk({tag, " bd_rdata0"}, 32'(bd_rdata0), 32'(e0));
  endtask

  task automatic trace_check(input string tag);
    chk({tag, " last_wr_addr"}, 32'(last_wr_addr), 32'(e_addr));
    chk({tag, " last_wr_data"}, 32'(last_wr_data), 32'(e_data));
    chk({tag, " last_wr_io"}, 32'(last_wr_io), 32'(e_io));
    chk({tag, " wr_count"}, 32'(wr_count), 32'(e_wr));
    chk({tag, " m1_count"}, 32'(m1_count), 32'(e_m1));
    chk({tag, " wr_count0"}, 32'(wr_count0), 32'(e_wr));
    chk({tag, " m1_count0"}, 32'(m1_count0), 32'(e_m1));
  endtask

  // One bus access held for 8 clocks; bd_at selects the clock whose posedge
  // also sees bd_we high (0 = none).
  task automatic bus_cycle(input string tag, input acc_kind_t kind, input logic is_wr,
                           input logic m1, input logic [15:0] addr, input logic [7:0] data,
                           input int exp_waits, input int bd_at);
    int   lows, lows0;
    exp_t e;
    bus.A = addr; bus.dout = data; bus.m1_n = ~m1;
    if (kind == ACC_MEM) bus.mreq_n = 1'b0;
    else bus.iorq_n = 1'b0;
    if (kind == ACC_INTA) bus.m1_n = 1'b0;
    else if (is_wr) bus.wr_n = 1'b0;
    else bus.rd_n = 1'b0;
    if (!is_wr) begin
      if (kind == ACC_MEM) e = '{d: mem_m[int'(addr)], d0: mem0_m[int'(addr)]};
      else if (kind == ACC_IO) e = '{d: mem_m[32'h10000 + int'(addr[7:0])],
                                     d0: mem0_m[32'h10000 + int'(addr[7:0])]};
      else e = '{d: 8'hFF, d0: 8'hFF};
      exp_q.push_back(e);
    end
    lows = 0; lows0 = 0;
    for (int i = 1; i <= 8; i++) begin
      bd_we = (i == bd_at);
      @(posedge clk); @(negedge clk);
      if (bus.wait_n !== 1'b1) lows++;
      if (bus0.wait_n !== 1'b1) lows0++;
    end
    bd_we = 1'b0;
    if (!is_wr) begin
      e = exp_q.pop_front();
      chk({tag, " di"}, 32'(bus.di), 32'(e.d));
      chk({tag, " di0"}, 32'(bus0.di), 32'(e.d0));
    end
    bus_idle();
    repeat (2) @(negedge clk);
    chk({tag, " wait cycles"}, 32'(lows), 32'(exp_waits));
    chk({tag, " wait cycles0"}, 32'(lows0), 32'd0);
    if (is_wr && kind != ACC_INTA) begin
      e_addr = addr; e_data = data; e_io = (kind == ACC_IO);
      e_wr = e_wr + 16'd1;
      if (kind == ACC_IO) begin
        mem_m[32'h10000 + int'(addr[7:0])] = data;
        mem0_m[32'h10000 + int'(addr[7:0])] = data;
      end else if (bd_at == 0) begin
        mem_m[int'(addr)] = data;
        mem0_m[int'(addr)] = data;
      end
    end
    if (!is_wr && kind == ACC_MEM && m1) e_m1 = e_m1 + 16'd1;
  endtask

  initial begin
    bus_idle();
    bus.A = 16'h0000; bus.dout = 8'h00;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("reset di", 32'(bus.di), 32'hFF);
    chk("reset di0", 32'(bus0.di), 32'hFF);
    chk("reset wait_n", 32'(bus.wait_n), 32'd1);
    chk("reset bd_rdata", 32'(bd_rdata), 32'd0);
    trace_check("reset");
    reset = 1'b0;
    @(negedge clk);

    // DDCB 62 8B with IX=1685: RES 1,(IX+62) on 16E7.
    bd_write(16'h0000, 8'hDD);
    bd_write(16'h0001, 8'hCB);
    bd_write(16'h0002, 8'h62);
    bd_write(16'h0003, 8'h8B);
    bd_write(16'h16E7, 8'h8A);

    // Refresh with a read strobe is not an access: di keeps its reset value.
    bus.A = 16'h0000; bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; bus.rd_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("refresh di", 32'(bus.di), 32'hFF);
    chk("refresh wait_n", 32'(bus.wait_n), 32'd1);
    bus_idle();
    repeat (2) @(negedge clk);

    bus_cycle("fetch DD", ACC_MEM, 1'b0, 1'b1, 16'h0000, 8'h00, 2, 0);
    bus_cycle("fetch CB", ACC_MEM, 1'b0, 1'b1, 16'h0001, 8'h00, 2, 0);
    bus_cycle("read d", ACC_MEM, 1'b0, 1'b0, 16'h0002, 8'h00, 2, 0);
    bus_cycle("read op", ACC_MEM, 1'b0, 1'b0, 16'h0003, 8'h00, 2, 0);
    bus_cycle("read 16E7", ACC_MEM, 1'b0, 1'b0, 16'h16E7, 8'h00, 2, 0);
    bus_cycle("write 16E7", ACC_MEM, 1'b1, 1'b0, 16'h16E7, 8'h88, 2, 0);
    trace_check("ddcb");
    chk("ddcb e_m1 model", 32'(m1_count), 32'd2);
    bd_check("ddcb", 16'h16E7, 8'h88, 8'h88);

    // IO write then read back.
    bus_cycle("io write 34", ACC_IO, 1'b1, 1'b0, 16'h0034, 8'h5A, 1, 0);
    bus_cycle("io read 34", ACC_IO, 1'b0, 1'b0, 16'h0034, 8'h00, 1, 0);
    trace_check("io");

    // Interrupt acknowledge.
    bus_cycle("inta", ACC_INTA, 1'b0, 1'b1, 16'h0000, 8'h00, 0, 0);
    trace_check("inta");

    // Collision: backdoor 11 and bus commit 22 to 1000 on the same posedge of
    // the waited responder; the zero-wait twin commits earlier so backdoor lands last.
    bd_addr = 16'h1000; bd_wdata = 8'h11;
    bus_cycle("collide write", ACC_MEM, 1'b1, 1'b0, 16'h1000, 8'h22, 2, 4);
    mem_m[32'h1000] = 8'h22;
    mem0_m[32'h1000] = 8'h11;
    trace_check("collide");
    bd_check("collide", 16'h1000, 8'h22, 8'h11);
    bus_cycle("read 1000", ACC_MEM, 1'b0, 1'b0, 16'h1000, 8'h00, 2, 0);

    // Reset in the middle of the wait phase of a write to 2000.
    bd_write(16'h2000, 8'h77);
    bus.A = 16'h2000; bus.dout = 8'h99; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midwait wait_n", 32'(bus.wait_n), 32'd0);
    reset = 1'b1;
    #1;
    chk("reset async wait_n", 32'(bus.wait_n), 32'd1);
    chk("reset async di", 32'(bus.di), 32'hFF);
    chk("reset async wr_count", 32'(wr_count), 32'd0);
    chk("reset async wr_count0", 32'(wr_count0), 32'd0);
    chk("reset async last_wr_addr", 32'(last_wr_addr), 32'd0);
    repeat (2) @(negedge clk);
    bus_idle();
    @(negedge clk);
    reset = 1'b0;
    e_addr = 16'h0000; e_data = 8'h00; e_io = 1'b0; e_wr = 16'h0000; e_m1 = 16'h0000;
    repeat (2) @(negedge clk);
    bd_check("after reset", 16'h2000, 8'h77, 8'h77);
    chk("after reset di", 32'(bus.di), 32'hFF);
    trace_check("after reset");

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

  // Time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
